// File: rtl/sbox_bram_scheduler.sv
// sbox_bram_scheduler: streams one masked 128-bit share through a dual-port
// masked S-box BRAM, two bytes per cycle (port A even bytes, port B odd
// bytes), realigns the delayed read data and returns the substituted share.
module sbox_bram_scheduler #(
  parameter int NBYTES = 16,
  parameter int SEL_W  = 2,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*NBYTES-1:0]       state_in,
  input  logic [SEL_W*NBYTES-1:0]   sel_in,
  output logic                      busy,
  output logic                      done,
  output logic [8*NBYTES-1:0]       state_out,
  output logic                      bram_en,
  output logic                      bram_rst,
  output logic [8+SEL_W-1:0]        bram_addra,
  output logic [8+SEL_W-1:0]        bram_addrb,
  input  logic [7:0]                bram_doa,
  input  logic [7:0]                bram_dob
);

  localparam int NPAIRS = NBYTES / 2;
  localparam int KW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NPAIRS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [DW-1:0]             dcnt_q, dcnt_d;
  logic [8*NBYTES-1:0]       data_q, data_d;
  logic [SEL_W*NBYTES-1:0]   sel_q, sel_d;
  logic [8*NBYTES-1:0]       out_q, out_d;
  logic [RD_LAT-1:0]         vld_q;
  logic [KW-1:0]             idx_q [RD_LAT];
  logic                      bramRst_q;
  logic                      issue;

  assign issue = (state_q == ISSUE);

  // Sequencing: accept a request in IDLE/DONE, walk the pair counter, then wait out the read latency.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          data_d  = state_in;
          sel_d   = sel_in;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Returned bytes land in their slot when the matching issue slot reaches the end of the delay line.
  always_comb begin
    out_d = out_q;
    if (vld_q[RD_LAT-1]) begin
      out_d[16*idx_q[RD_LAT-1] +: 8]     = bram_doa;
      out_d[16*idx_q[RD_LAT-1] + 8 +: 8] = bram_dob;
    end
  end

  // Addresses are a plain concatenation of the latched selector and byte for the current pair.
  always_comb begin
    bram_addra = {sel_q[2*SEL_W*k_q +: SEL_W],         data_q[16*k_q +: 8]};
    bram_addrb = {sel_q[2*SEL_W*k_q + SEL_W +: SEL_W], data_q[16*k_q + 8 +: 8]};
  end

  // Control, latched operands and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  // Valid/index delay line that matches the BRAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      idx_q[0] <= k_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  // BRAM output reset is held during reset and still seen by the first clock edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bramRst_q <= 1'b1;
    else      bramRst_q <= 1'b0;
  end

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign bram_en   = busy;
  assign done      = (state_q == DONE);
  assign state_out = out_q;
  assign bram_rst  = bramRst_q;

endmodule

// File: tb/tb_sbox_bram_scheduler.sv
// Self-checking bench for sbox_bram_scheduler: behavioural BRAM, timeline
// model of the handshake and per-byte lookup model of the result.
module tb_sbox_bram_scheduler;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  state_in;
  logic [31:0]   sel_in;
  logic          busy;
  logic          done;
  logic [127:0]  state_out;
  logic          bram_en;
  logic          bram_rst;
  logic [9:0]    bram_addra;
  logic [9:0]    bram_addrb;
  logic [7:0]    bram_doa;
  logic [7:0]    bram_dob;
  logic [7:0]    rdA;
  logic [7:0]    rdB;

  int checks   = 0;
  int failures = 0;

  sbox_bram_scheduler #(.NBYTES(16), .SEL_W(2), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in), .sel_in(sel_in),
    .busy(busy), .done(done), .state_out(state_out), .bram_en(bram_en),
    .bram_rst(bram_rst), .bram_addra(bram_addra), .bram_addrb(bram_addrb),
    .bram_doa(bram_doa), .bram_dob(bram_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'b0};
  endfunction

  function automatic logic [127:0] subst(input logic [127:0] s, input logic [31:0] sl);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = rom({sl[2*i +: 2], s[8*i +: 8]});
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural dual-port BRAM: array read register, then output register gated by REGCE.
  always @(posedge clk) begin
    if (bram_en) begin
      rdA <= rom(bram_addra);
      rdB <= rom(bram_addrb);
    end
    if (bram_rst) begin
      bram_doa <= 8'h00;
      bram_dob <= 8'h00;
    end else if (bram_en) begin
      bram_doa <= rdA;
      bram_dob <= rdB;
    end
  end

  // Timeline model: an accepted request starts at cycle c0; busy for 10 cycles, done at offset 10.
  int           cyc = 0;
  bit           haveOp = 0;
  int           c0 = 0;
  int           prevRel;
  int           rel;
  int           p;
  bit           prevBusy;
  bit           busyExp;
  bit           doneExp;
  logic [127:0] mState = '0;
  logic [31:0]  mSel = '0;
  logic [127:0] lastRes = '0;

  // Compare process: one step after every rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      haveOp  = 0;
      lastRes = '0;
      checkOutput("rst_bram_rst", bram_rst, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_en", bram_en, 1'b0);
      checkOutput("rst_state_out", state_out, '0);
      checkOutput("rst_addra", bram_addra, '0);
      checkOutput("rst_addrb", bram_addrb, '0);
    end else begin
      prevRel  = cyc - 1 - c0;
      prevBusy = haveOp && (prevRel >= 0) && (prevRel <= 9);
      if (start && !prevBusy) begin
        haveOp = 1;
        c0     = cyc;
        mState = state_in;
        mSel   = sel_in;
      end
      rel     = cyc - c0;
      busyExp = haveOp && (rel >= 0) && (rel <= 9);
      doneExp = haveOp && (rel == 10);
      checkOutput("bram_rst", bram_rst, 1'b0);
      checkOutput("busy", busy, busyExp);
      checkOutput("bram_en", bram_en, busyExp);
      checkOutput("done", done, doneExp);
      if (busyExp) begin
        p = (rel < 8) ? rel : 7;
        checkOutput("addra", bram_addra, {mSel[4*p +: 2], mState[16*p +: 8]});
        checkOutput("addrb", bram_addrb, {mSel[4*p + 2 +: 2], mState[16*p + 8 +: 8]});
      end
      if (doneExp) lastRes = subst(mState, mSel);
      if (!(busyExp && rel >= 3)) checkOutput("state_out", state_out, lastRes);
    end
  end

  // Issues one request (now, or at the next falling edge) and waits for done with a cycle budget.
  task automatic applyStimulus(input logic [127:0] s, input logic [31:0] sl, input bit now,
                               output int lat, output int busyCnt);
    if (!now) @(negedge clk);
    start    = 1'b1;
    state_in = s;
    sel_in   = sl;
    lat      = 0;
    busyCnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busyCnt++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=%0d expected=%0d", lat, 11);
    end
  endtask

  int           lat;
  int           busyCnt;
  int           doneCnt;
  logic [127:0] orig;
  logic [31:0]  origSel;
  logic [127:0] snap;

  initial begin
    start    = 1'b0;
    state_in = '0;
    sel_in   = '0;
    rst      = 1'b1;
    #1 rst   = 1'b0;

    // Reset held for three cycles, then released away from the edge.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("bram_rst_after_release", bram_rst, 1'b1);

    // Identity lookups with zero selectors.
    applyStimulus(128'h00112233445566778899AABBCCDDEEFF, 32'h0, 1'b0, lat, busyCnt);
    checkOutput("basic_result", state_out, 128'h00112233445566778899AABBCCDDEEFF);
    checkOutput("basic_latency", lat, 11);
    checkOutput("basic_busy_cycles", busyCnt, 10);

    // Selector bits flow into the address MSBs.
    applyStimulus(128'h0, 32'hFFFFFFFF, 1'b0, lat, busyCnt);
    checkOutput("sel_result", state_out, {16{8'hC0}});

    // Back-to-back: new request driven during the done cycle.
    applyStimulus(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 32'h1B2C3D4E, 1'b0, lat, busyCnt);
    applyStimulus(128'hDEADBEEF0123456789ABCDEFFEEDC0DE, 32'hA5A55A5A, 1'b1, lat, busyCnt);
    checkOutput("b2b_gap", lat, 11);
    checkOutput("b2b_busy_cycles", busyCnt, 10);
    checkOutput("b2b_result", state_out, subst(128'hDEADBEEF0123456789ABCDEFFEEDC0DE, 32'hA5A55A5A));

    // Stray start pulses while busy are ignored.
    @(negedge clk);
    orig     = {$urandom, $urandom, $urandom, $urandom};
    origSel  = $urandom;
    start    = 1'b1;
    state_in = orig;
    sel_in   = origSel;
    doneCnt  = 0;
    snap     = '0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 8);
      if (start) begin
        state_in = {$urandom, $urandom, $urandom, $urandom};
        sel_in   = $urandom;
      end
      if (done) begin
        doneCnt++;
        snap = state_out;
      end
    end
    start = 1'b0;
    checkOutput("stray_done_count", doneCnt, 1);
    checkOutput("stray_result", snap, subst(orig, origSel));

    // Abort in the middle of ISSUE.
    @(negedge clk);
    start    = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    sel_in   = $urandom;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    checkOutput("abort_state_out", state_out, '0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_bram_rst", bram_rst, 1'b1);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", doneCnt, 0);
    applyStimulus(128'h3243F6A8885A308D313198A2E0370734, 32'h6C8E21F9, 1'b0, lat, busyCnt);
    checkOutput("after_abort_latency", lat, 11);
    checkOutput("after_abort_result", state_out, subst(128'h3243F6A8885A308D313198A2E0370734, 32'h6C8E21F9));

    // Randomized traffic: random operands, random start pulses, checked by the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      state_in = {$urandom, $urandom, $urandom, $urandom};
      sel_in   = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
